// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - I2S receiver: oversamples sck/lrck/sdin in clk domain and rebuilds left/right PCM words
// Malformed (short) slots raise a one-clock frame_err instead of committing a word.
module i2s_rx_deser #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              lrck,
  input  logic              sdin,
  output logic [DATA_W-1:0] ldata_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              ldata_valid,
  output logic              rdata_valid,
  output logic              frame_err
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] sdin_sync;
  logic                   sck_s;
  logic                   sck_d;
  logic                   rise_q;
  logic                   lrck_q;
  logic                   sdin_q;
  logic                   lrck_prev;
  logic                   ws_edge;

  state_t                 state;
  state_t                 state_nx;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       cnt_nx;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   chan;
  logic                   chan_nx;
  logic [DATA_W-1:0]      shreg;
  logic [DATA_W-1:0]      shreg_nx;
  logic [DATA_W-1:0]      shifted;
  logic                   commit;
  logic                   err_nx;

  assign sck_s = sck_sync[SYNC_STAGES-1];

  // lrck/sdin go through the same depth as sck so they stay aligned with the detected rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      lrck_sync <= '0;
      sdin_sync <= '0;
      sck_d     <= 1'b0;
      rise_q    <= 1'b0;
      lrck_q    <= 1'b0;
      sdin_q    <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
      sck_d     <= sck_s;
      rise_q    <= sck_s & ~sck_d;
      lrck_q    <= lrck_sync[SYNC_STAGES-1];
      sdin_q    <= sdin_sync[SYNC_STAGES-1];
      if (rise_q) begin
        lrck_prev <= lrck_q;
      end
    end
  end

  assign ws_edge = rise_q & (lrck_q ^ lrck_prev);
  assign shifted = {shreg[DATA_W-2:0], sdin_q};
  assign cnt_inc = bit_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SYNC;
      bit_cnt <= '0;
      chan    <= 1'b0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= cnt_nx;
      chan    <= chan_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    chan_nx  = chan;
    shreg_nx = shreg;
    commit   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      SYNC: begin
        if (ws_edge) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
          chan_nx  = lrck_q;
        end
      end
      SHIFT: begin
        if (ws_edge) begin
          // The bit sampled on the word-select edge is the old slot's LSB
          if (bit_cnt == CNT_LAST) begin
            shreg_nx = shifted;
            commit   = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
          cnt_nx  = '0;
          chan_nx = lrck_q;
        end else if (rise_q) begin
          shreg_nx = shifted;
          cnt_nx   = cnt_inc;
          if (cnt_inc == CNT_FULL) begin
            commit   = 1'b1;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (ws_edge) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
          chan_nx  = lrck_q;
        end
      end
      default: begin
        state_nx = SYNC;
        cnt_nx   = '0;
      end
    endcase
  end

  // commit refers to the registered chan, i.e. the slot that just ended
  always_ff @(posedge clk) begin
    if (rst) begin
      ldata_out   <= '0;
      rdata_out   <= '0;
      ldata_valid <= 1'b0;
      rdata_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      ldata_valid <= commit & ~chan;
      rdata_valid <= commit & chan;
      frame_err   <= err_nx;
      if (commit && !chan) begin
        ldata_out <= shreg_nx;
      end
      if (commit && chan) begin
        rdata_out <= shreg_nx;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb/tb_i2s_rx_deser.sv - scoreboard bench for i2s_rx_deser: slot formats, short slot, reset, latency
module tb_i2s_rx_deser;

  localparam int K_L = 0;
  localparam int K_R = 1;
  localparam int K_E = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic        lrck;
  logic        sdin;
  logic [15:0] ldata_out;
  logic [15:0] rdata_out;
  logic        ldata_valid;
  logic        rdata_valid;
  logic        frame_err;

  i2s_rx_deser #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .lrck       (lrck),
    .sdin       (sdin),
    .ldata_out  (ldata_out),
    .rdata_out  (rdata_out),
    .ldata_valid(ldata_valid),
    .rdata_valid(rdata_valid),
    .frame_err  (frame_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          half_clks = 50;
  logic        prev_d = 1'b0;
  int          mon_kind;
  logic [15:0] mon_data;
  exp_t        mon_e;

  // Scoreboard consumer: every pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst && (ldata_valid || rdata_valid || frame_err)) begin
      checks++;
      mon_kind = ldata_valid ? K_L : (rdata_valid ? K_R : K_E);
      mon_data = ldata_valid ? ldata_out : (rdata_valid ? rdata_out : 16'h0000);
      if ((int'(ldata_valid) + int'(rdata_valid) + int'(frame_err)) > 1) begin
        failures++;
        $display("FAIL pulse_overlap: lv=%0b rv=%0b err=%0b required at most one", ldata_valid, rdata_valid, frame_err);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: kind=%0d data=%h required no pulse", mon_kind, mon_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_kind !== mon_e.kind || (mon_kind != K_E && mon_data !== mon_e.data)) begin
          failures++;
          $display("FAIL scoreboard: kind=%0d data=%h required kind=%0d data=%h", mon_kind, mon_data, mon_e.kind, mon_e.data);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input int kind, input logic [15:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    sck    = 1'b0;
    lrck   = 1'b0;
    sdin   = 1'b0;
    prev_d = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wire_bit(input logic lr, input logic d);
    @(negedge clk);
    sck  = 1'b0;
    lrck = lr;
    sdin = d;
    repeat (half_clks - 1) @(negedge clk);
    sck = 1'b1;
    repeat (half_clks - 1) @(negedge clk);
  endtask

  // Wire data trails lrck by one bit, which is the I2S framing
  task automatic send_logical(input logic lr, input logic d);
    wire_bit(lr, prev_d);
    prev_d = d;
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] word, input int len);
    for (int i = 0; i < len; i++) begin
      send_logical(lr, (i < 16) ? word[15 - i] : 1'b0);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d pulses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] l, input logic [15:0] r);
    checks++;
    if (ldata_out !== l) begin
      failures++;
      $display("FAIL %s_ldata: got %h required %h", name, ldata_out, l);
    end
    checks++;
    if (rdata_out !== r) begin
      failures++;
      $display("FAIL %s_rdata: got %h required %h", name, rdata_out, r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sck = 1'b1;
    lrck = 1'b1;
    sdin = 1'b1;
    repeat (4) @(negedge clk);
    do_reset();
    @(negedge clk);
    check_out("reset", 16'h0000, 16'h0000);
    checks++;
    if ({ldata_valid, rdata_valid, frame_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses: got %b required 000", {ldata_valid, rdata_valid, frame_err});
    end
  endtask

  task automatic test_slots32();
    half_clks = 50;
    do_reset();
    send_slot(1'b0, 16'hA5C3, 32);
    push(K_R, 16'h1234);
    send_slot(1'b1, 16'h1234, 32);
    push(K_L, 16'hA5C3);
    send_slot(1'b0, 16'hA5C3, 32);
    push(K_R, 16'h1234);
    send_slot(1'b1, 16'h1234, 32);
    wait_drain("slots32");
    check_out("slots32", 16'hA5C3, 16'h1234);
  endtask

  task automatic test_slots16();
    half_clks = 8;
    do_reset();
    send_slot(1'b0, 16'h8001, 16);
    push(K_R, 16'h7FFE);
    send_slot(1'b1, 16'h7FFE, 16);
    push(K_L, 16'h8001);
    send_slot(1'b0, 16'h8001, 16);
    push(K_R, 16'h7FFE);
    send_slot(1'b1, 16'h7FFE, 16);
    push(K_L, 16'h8001);
    send_slot(1'b0, 16'h8001, 16);
    send_logical(1'b1, 1'b0);
    wait_drain("slots16");
    check_out("slots16", 16'h8001, 16'h7FFE);
  endtask

  task automatic test_short_slot();
    half_clks = 8;
    do_reset();
    send_slot(1'b0, 16'h0000, 16);
    push(K_R, 16'h0F0F);
    send_slot(1'b1, 16'h0F0F, 16);
    push(K_L, 16'h3C3C);
    send_slot(1'b0, 16'h3C3C, 16);
    push(K_R, 16'h0F0F);
    send_slot(1'b1, 16'h0F0F, 16);
    push(K_E, 16'h0000);
    send_slot(1'b0, 16'h2AAA, 10);
    push(K_R, 16'h00FF);
    send_slot(1'b1, 16'h00FF, 16);
    send_logical(1'b0, 1'b0);
    wait_drain("short_slot");
    check_out("short_slot", 16'h3C3C, 16'h00FF);
  endtask

  task automatic test_reset_mid_word();
    half_clks = 8;
    do_reset();
    send_slot(1'b0, 16'h0000, 32);
    push(K_R, 16'h1111);
    send_slot(1'b1, 16'h1111, 32);
    wait_drain("midrst_pre");
    send_slot(1'b0, 16'h5A5A, 8);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("midrst_cleared", 16'h0000, 16'h0000);
    checks++;
    if ({ldata_valid, rdata_valid, frame_err} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_pulses: got %b required 000", {ldata_valid, rdata_valid, frame_err});
    end
    send_slot(1'b0, 16'h0000, 24);
    push(K_R, 16'h5555);
    send_slot(1'b1, 16'h5555, 32);
    wait_drain("midrst");
    check_out("midrst", 16'h0000, 16'h5555);
  endtask

  task automatic test_latency();
    int  cnt;
    logic seen;
    half_clks = 8;
    do_reset();
    send_slot(1'b0, 16'h0000, 16);
    push(K_R, 16'h1357);
    send_slot(1'b1, 16'h1357, 16);
    push(K_L, 16'h2468);
    send_slot(1'b0, 16'h2468, 16);
    @(negedge clk);
    sck  = 1'b0;
    lrck = 1'b1;
    sdin = prev_d;
    repeat (half_clks - 1) @(negedge clk);
    sck  = 1'b1;
    cnt  = 0;
    seen = 1'b0;
    while (cnt < 20 && !seen) begin
      @(posedge clk);
      #1;
      cnt++;
      if (ldata_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || cnt != 4) begin
      failures++;
      $display("FAIL latency: seen=%0b after %0d clk, required valid after 4 clk", seen, cnt);
    end
    repeat (half_clks - 1) @(negedge clk);
    wait_drain("latency");
  endtask

  task automatic test_full_scale();
    half_clks = 8;
    do_reset();
    send_slot(1'b0, 16'h0000, 32);
    push(K_R, 16'hFFFF);
    send_slot(1'b1, 16'hFFFF, 32);
    push(K_L, 16'h8000);
    send_slot(1'b0, 16'h8000, 32);
    wait_drain("full_scale");
    check_out("full_scale", 16'h8000, 16'hFFFF);
  endtask

  initial begin
    rst  = 1'b1;
    sck  = 1'b0;
    lrck = 1'b0;
    sdin = 1'b0;
    test_reset();
    test_slots32();
    test_slots16();
    test_short_slot();
    test_reset_mid_word();
    test_latency();
    test_full_scale();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
